// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the XOR-sharing arbiter.
// The optional per-requester grant counters (XOR_ARB_CNT_EN) use CNT_W / CNT_MAX.
package xor_arb_pkg;

    // Result register occupancy: EMPTY means no result is held, FULL means one is.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    localparam int               CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker. Purely combinational and reusable by any
// shared-resource controller: the search starts at ptr, scans upward with
// wrap, and grants the first asserted request.
module rr_pick
    import xor_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             any
);

    // Walk the requesters in priority order starting at ptr; first hit wins.
    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/xor_share_arbiter.sv
// Time-shares one WIDTH-bit XOR datapath among N_REQ requesters with a
// round-robin grant and a single-entry result register.
//
// Handshakes: a transfer happens on a port in any cycle where its valid and
// ready are both 1. A requester raising req_valid holds it and its operands
// until accepted; the result stays stable while res_valid=1 and res_ready=0.
//
// Optional feature: define XOR_ARB_CNT_EN to add the grant_cnt port with
// saturating per-requester handshake counters.
module xor_share_arbiter
    import xor_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_y,
    output logic [IDW-1:0]         res_id,
`ifdef XOR_ARB_CNT_EN
    output logic [N_REQ*CNT_W-1:0] grant_cnt,
`endif
    output arb_state_t             state_dbg
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [IDW-1:0]   ptr_q;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    logic             any;
    logic             can_issue;
    logic             hs;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // Issue is allowed when the result slot is free or being drained this
    // cycle; never while reset is asserted.
    always_comb begin
        can_issue = rst_n & ((state_q == ST_EMPTY) | res_ready);
        hs        = can_issue & any;
        sel_a     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
        sel_b     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // State register: occupancy of the result slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // Next state: a handshake always fills; a drain without refill empties.
    always_comb begin
        state_d = state_q;
        if (hs)
            state_d = ST_FULL;
        else if (state_q == ST_FULL && res_ready)
            state_d = ST_EMPTY;
    end

    // Outputs derived from state and the issue window.
    always_comb begin
        res_valid = (state_q == ST_FULL);
        req_ready = grant & {N_REQ{can_issue}};
        state_dbg = state_q;
    end

    // Result register and rotation pointer load only on a handshake; on a
    // drain without refill the stale result is intentionally kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y  <= '0;
            res_id <= '0;
            ptr_q  <= '0;
        end else if (hs) begin
            res_y  <= sel_a ^ sel_b;
            res_id <= grant_idx;
            ptr_q  <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef XOR_ARB_CNT_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        // Saturating count of handshakes for requester i.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt_q <= '0;
            else if (hs && grant[i] && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + 1'b1;
        end

        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: doc/xor_share_arbiter.md
# xor_share_arbiter

Time-shares one WIDTH-bit XOR datapath among N_REQ requesters under a round-robin policy, with valid/ready handshakes on each request port and on the single result port. The block sits between the requester-side operand sources and any consumer of XOR results. It holds exactly one result in an output register. Issue is fully pipelined, so it accepts one operation per cycle when the consumer keeps up.

## Interface
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, operand and result width in bits
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N_REQ  per-requester operation valid
- req_ready  output  N_REQ  per-requester accept; one-hot or zero
- req_a  input  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  input  N_REQ*WIDTH  operand B; same packing as req_a
- res_valid  output  1  result register holds a result
- res_ready  input  1  consumer accepts result
- res_y  output  WIDTH  stored a^b
- res_id  output  IDW=$clog2(N_REQ)  index of the requester that produced res_y
- grant_cnt  output  N_REQ*16  per-requester accept count; present only with XOR_ARB_CNT_EN

## Operation
- State machine with two states, kept in the result register:
  - EMPTY (res_valid=0)
  - FULL (res_valid=1)
- can_issue = EMPTY | (FULL & res_ready).
- Grant is combinational. Search starts at pointer ptr and scans upward with wrap, selecting the first i with req_valid[i].
- req_ready[i] = grant[i] & can_issue.
- A handshake on port i happens when req_valid[i] & req_ready[i]. On a handshake:
  - res_y <= a_i ^ b_i
  - res_id <= i
  - res_valid <= 1
  - ptr <= (i+1) mod N_REQ
- If there is no handshake, ptr holds.
- FULL & res_ready with no handshake -> EMPTY. res_y and res_id hold their stale values.
- FULL & res_ready with a handshake on the same cycle -> stays FULL and loads the new result. There is no bubble.
- FULL & !res_ready -> all req_ready are 0. res_y and res_id stay stable until consumed.
- A requester holding req_valid waits at most N_REQ-1 handshakes by other requesters, provided res_ready is eventually asserted.
- Operand inputs are sampled only on the handshake cycle. Once req_valid is raised, the requester holds req_valid and its operands until accepted.
- Reset values: res_valid=0, res_y=0, res_id=0, ptr=0, grant_cnt=0, req_ready=0.
- Reset mid-operation discards the held result immediately. No handshake completes during reset.

## Timing
- Latency from handshake to res_valid/res_y is 1 cycle, registered.
- Throughput is 1 result per cycle while res_ready=1.
- req_ready depends combinationally on req_valid, ptr, res_valid and res_ready. It does not depend on operand values.
- res_valid, res_y and res_id are pure register outputs with no combinational path from inputs.
- Rotation wrap: when the last grant went to N_REQ-1, ptr becomes 0.

## Configuration
- XOR_ARB_CNT_EN defined:
  - Adds the grant_cnt port.
  - Counter i increments by 1 on each handshake of requester i and saturates at 16'hFFFF (no wrap).
  - Counters are cleared only by rst_n.
- XOR_ARB_CNT_EN undefined: the grant_cnt port and counters are absent. All other behaviour is identical.

## Structure
- Package xor_arb_pkg contains:
  - state enum {ST_EMPTY, ST_FULL}
  - CNT_W=16
  - CNT_MAX=16'hFFFF
- Sub-module rr_pick: N_REQ-wide round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational; reused by other shared-resource controllers.
- The top level holds ptr, the result register, the FSM and the optional counters.

## Test plan
- Reset check: assert rst_n=0 with random inputs -> res_valid=0, req_ready=0, res_y=0, res_id=0, grant_cnt=0.
- Single request, N_REQ=4, WIDTH=8: req_valid=4'b0100, a=8'hA5, b=8'h0F, res_ready=1 -> req_ready=4'b0100 that cycle; next cycle res_valid=1, res_y=8'hAA, res_id=2, ptr=3.
- Fairness: all four req_valid held high, res_ready=1 -> grants in order 0,1,2,3,0, one per cycle, with no idle cycles.
- Backpressure: res_ready=0 after the first result -> req_ready=0 and res_y/res_id stable for 5 cycles. Raising res_ready consumes the result and issues the next operation in the same cycle; res_valid stays 1.
- Reset mid-operation: drop rst_n while FULL with res_ready=0 -> res_valid=0 asynchronously; after release the first grant goes to requester 0.
- Counter saturation (with XOR_ARB_CNT_EN): requester 1 makes 65537 handshakes -> grant_cnt[31:16]=16'hFFFF, and all other counters stay 0.
